// File: rtl/servo_pkg.sv
// Shared constants, width type, FSM state encoding and clamp helper
// for the servo motion scheduler.
package servo_pkg;

   localparam int W_MIN    = 1000;
   localparam int W_MAX    = 2000;
   localparam int W_CENTER = 1500;
   localparam int STEP     = 10;

   typedef logic [15:0] width_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
      if (w < lo) begin
         return lo;
      end else if (w > hi) begin
         return hi;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/servo_slew_step.sv
// Combinational slew unit: moves cur toward target by at most STEP,
// snapping onto target once the remaining distance fits in one step.
module servo_slew_step #(
   parameter int STEP = servo_pkg::STEP
) (
   input  servo_pkg::width_t cur,
   input  servo_pkg::width_t target,
   output servo_pkg::width_t next_cur
);
   import servo_pkg::*;

   localparam logic signed [16:0] STEP_S = 17'(STEP);

   logic signed [16:0] diff;

   // Widen to 17 signed bits so the full 16-bit difference keeps its sign.
   always_comb begin
      diff     = $signed({1'b0, target}) - $signed({1'b0, cur});
      next_cur = target;
      if (diff > STEP_S) begin
         next_cur = cur + width_t'(STEP);
      end else if (diff < -STEP_S) begin
         next_cur = cur - width_t'(STEP);
      end
   end

endmodule

// File: rtl/servo_motion_ctrl.sv
// Servo motion scheduler: clamped per-channel targets from a command port,
// slewed once per update tick by a single shared step unit.
module servo_motion_ctrl #(
   parameter  int N_CH     = 5,
   parameter  int TICK_DIV = 250000,
   parameter  int STEP     = servo_pkg::STEP,
   parameter  int W_MIN    = servo_pkg::W_MIN,
   parameter  int W_MAX    = servo_pkg::W_MAX,
   parameter  int W_CENTER = servo_pkg::W_CENTER,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              home,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic [15:0]       cmd_width,
   output logic [N_CH*16-1:0] width_us,
   output logic [N_CH-1:0]   at_target,
   output logic              all_done,
   output logic              clamp_err,
   output logic              ch_err
);
   import servo_pkg::*;

   localparam int     TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam width_t MIN_W    = width_t'(W_MIN);
   localparam width_t MAX_W    = width_t'(W_MAX);
   localparam width_t CENTER_W = width_t'(W_CENTER);

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [CH_W-1:0] ch_idx;
   logic            scan_last;
   width_t          cur    [N_CH];
   width_t          target [N_CH];
   width_t          slew_next;
   width_t          cmd_clamped;
   logic            accept;
   logic            ch_bad;

   assign tick        = en && (tick_cnt == TW'(TICK_DIV - 1));
   assign scan_last   = (ch_idx == CH_W'(N_CH - 1));
   assign accept      = cmd_valid && cmd_ready;
   assign ch_bad      = int'(cmd_ch) >= N_CH;
   assign cmd_clamped = clamp_width(cmd_width, MIN_W, MAX_W);

   // Free-running update-tick divider; holds its count while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (en) begin
         tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A tick seen outside IDLE is dropped; the divider keeps scans far apart.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = !rst;
            if (tick) begin
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (scan_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_idx <= '0;
      end else if (state == IDLE) begin
         ch_idx <= '0;
      end else begin
         ch_idx <= ch_idx + CH_W'(1);
      end
   end

   // home overrides any command landing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            target[i] <= CENTER_W;
         end
      end else if (home) begin
         for (int i = 0; i < N_CH; i++) begin
            target[i] <= CENTER_W;
         end
      end else if (accept && !ch_bad) begin
         target[cmd_ch] <= cmd_clamped;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clamp_err <= 1'b0;
         ch_err    <= 1'b0;
      end else begin
         clamp_err <= accept && !home && !ch_bad && (cmd_clamped != cmd_width);
         ch_err    <= accept && !home && ch_bad;
      end
   end

   servo_slew_step #(
      .STEP (STEP)
   ) u_slew (
      .cur      (cur[ch_idx]),
      .target   (target[ch_idx]),
      .next_cur (slew_next)
   );

   // One channel per SCAN cycle passes through the shared step unit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            cur[i] <= CENTER_W;
         end
      end else if (state == SCAN) begin
         cur[ch_idx] <= slew_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         at_target <= '1;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            at_target[i] <= (cur[i] == target[i]);
         end
      end
   end

   always_comb begin
      width_us = '0;
      for (int i = 0; i < N_CH; i++) begin
         width_us[16*i +: 16] = cur[i];
      end
   end

   assign all_done = &at_target;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Directed bench for servo_motion_ctrl with a shortened tick divider;
// expected widths are hand-derived from the slew rule.
module tb_servo_motion_ctrl;

   localparam int N_CH     = 5;
   localparam int TICK_DIV = 20;
   localparam int CH_W     = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic               home;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [CH_W-1:0]    cmd_ch;
   logic [15:0]        cmd_width;
   logic [N_CH*16-1:0] width_us;
   logic [N_CH-1:0]    at_target;
   logic               all_done;
   logic               clamp_err;
   logic               ch_err;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_w [N_CH];
   logic        seen_clamp;
   logic        seen_cherr;
   int          waited;
   int          lows;
   logic        any_low;

   servo_motion_ctrl #(
      .N_CH     (N_CH),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .home      (home),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_ch    (cmd_ch),
      .cmd_width (cmd_width),
      .width_us  (width_us),
      .at_target (at_target),
      .all_done  (all_done),
      .clamp_err (clamp_err),
      .ch_err    (ch_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] packed_exp();
      logic [79:0] v;
      v = '0;
      for (int i = 0; i < N_CH; i++) begin
         v[16*i +: 16] = exp_w[i];
      end
      return v;
   endfunction

   // Present a command (optionally with home) from a negedge and hold it until accepted.
   task automatic applyStimulus(input int ch, input int width, input logic with_home);
      cmd_valid = 1'b1;
      cmd_ch    = CH_W'(ch);
      cmd_width = 16'(width);
      home      = with_home;
      waited    = 0;
      while (!cmd_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      checkOutput("cmd_ready_seen", 80'(cmd_ready), 80'd1);
      @(posedge clk);
      @(negedge clk);
      seen_clamp = clamp_err;
      seen_cherr = ch_err;
      cmd_valid  = 1'b0;
      home       = 1'b0;
   endtask

   task automatic wait_ready_low();
      int n;
      n = 0;
      while (cmd_ready && n < TICK_DIV + 10) begin
         n++;
         @(negedge clk);
      end
      checkOutput("scan_start", 80'(cmd_ready), 80'd0);
   endtask

   task automatic count_low();
      lows = 0;
      while (!cmd_ready && lows < 20) begin
         lows++;
         @(negedge clk);
      end
      checkOutput("scan_len", 80'(lows), 80'(N_CH));
   endtask

   task automatic wait_scan();
      wait_ready_low();
      count_low();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      home      = 1'b0;
      cmd_valid = 1'b0;
      cmd_ch    = '0;
      cmd_width = '0;
      for (int i = 0; i < N_CH; i++) exp_w[i] = 16'd1500;

      repeat (3) @(negedge clk);
      checkOutput("ready_in_reset", 80'(cmd_ready), 80'd0);
      checkOutput("width_in_reset", 80'(width_us), packed_exp());
      rst = 1'b0;
      #1;
      checkOutput("reset_width", 80'(width_us), packed_exp());
      checkOutput("reset_at_target", 80'(at_target), 80'b11111);
      checkOutput("reset_all_done", 80'(all_done), 80'd1);
      checkOutput("reset_ready", 80'(cmd_ready), 80'd1);
      checkOutput("reset_errs", 80'({clamp_err, ch_err}), 80'd0);

      // ch2 ramp 1500 -> 1600 in ten ticks
      applyStimulus(2, 1600, 1'b0);
      checkOutput("ch2_no_clamp", 80'(seen_clamp), 80'd0);
      for (int k = 1; k <= 10; k++) begin
         wait_scan();
         exp_w[2] = 16'(1500 + 10 * k);
         checkOutput("ramp_ch2", 80'(width_us), packed_exp());
         checkOutput("ramp_at_target", 80'(at_target), (k == 10) ? 80'b11111 : 80'b11011);
      end

      applyStimulus(0, 1505, 1'b0);
      checkOutput("ch0_1505_clamp", 80'(seen_clamp), 80'd0);
      wait_scan();
      exp_w[0] = 16'd1505;
      checkOutput("snap_ch0", 80'(width_us), packed_exp());
      checkOutput("snap_at_target", 80'(at_target), 80'b11111);

      applyStimulus(0, 500, 1'b0);
      checkOutput("low_clamp_err", 80'(seen_clamp), 80'd1);
      checkOutput("low_ch_err", 80'(seen_cherr), 80'd0);
      wait_scan();
      exp_w[0] = 16'd1495;
      checkOutput("low_step", 80'(width_us), packed_exp());
      checkOutput("low_at_target", 80'(at_target), 80'b11110);

      applyStimulus(0, 2500, 1'b0);
      checkOutput("high_clamp_err", 80'(seen_clamp), 80'd1);
      wait_scan();
      exp_w[0] = 16'd1505;
      checkOutput("high_step", 80'(width_us), packed_exp());

      applyStimulus(0, 1500, 1'b0);
      wait_scan();
      exp_w[0] = 16'd1500;
      checkOutput("ch0_back", 80'(width_us), packed_exp());

      applyStimulus(7, 1700, 1'b0);
      checkOutput("bad_ch_err", 80'(seen_cherr), 80'd1);
      checkOutput("bad_ch_clamp", 80'(seen_clamp), 80'd0);
      wait_scan();
      checkOutput("bad_ch_widths", 80'(width_us), packed_exp());
      checkOutput("bad_ch_at_target", 80'(at_target), 80'b11111);

      // command held across a scan waits out all five SCAN cycles
      wait_ready_low();
      applyStimulus(3, 1520, 1'b0);
      checkOutput("held_wait", 80'(waited), 80'(N_CH));
      wait_scan();
      exp_w[3] = 16'd1510;
      checkOutput("held_step1", 80'(width_us), packed_exp());
      checkOutput("held_at_target", 80'(at_target), 80'b10111);
      wait_scan();
      exp_w[3] = 16'd1520;
      checkOutput("held_step2", 80'(width_us), packed_exp());

      // exact limits are not clamped; then park every channel at 1800
      applyStimulus(4, 1000, 1'b0);
      checkOutput("min_exact_clamp", 80'(seen_clamp), 80'd0);
      applyStimulus(4, 2000, 1'b0);
      checkOutput("max_exact_clamp", 80'(seen_clamp), 80'd0);
      for (int c = 0; c < N_CH; c++) applyStimulus(c, 1800, 1'b0);
      for (int k = 0; k < 34; k++) wait_scan();
      for (int i = 0; i < N_CH; i++) exp_w[i] = 16'd1800;
      checkOutput("all_1800", 80'(width_us), packed_exp());
      checkOutput("all_1800_done", 80'(all_done), 80'd1);

      applyStimulus(1, 1900, 1'b1);
      checkOutput("home_no_clamp", 80'(seen_clamp), 80'd0);
      checkOutput("home_no_ch_err", 80'(seen_cherr), 80'd0);
      wait_scan();
      for (int i = 0; i < N_CH; i++) exp_w[i] = 16'd1790;
      checkOutput("home_step1", 80'(width_us), packed_exp());
      checkOutput("home_at_target", 80'(at_target), 80'd0);
      wait_scan();
      for (int i = 0; i < N_CH; i++) exp_w[i] = 16'd1780;
      checkOutput("home_step2", 80'(width_us), packed_exp());

      // disabling mid-scan lets that scan finish, then freezes
      wait_ready_low();
      en = 1'b0;
      count_low();
      for (int i = 0; i < N_CH; i++) exp_w[i] = 16'd1770;
      checkOutput("en_off_scan_done", 80'(width_us), packed_exp());
      any_low = 1'b0;
      for (int k = 0; k < 3 * TICK_DIV; k++) begin
         @(negedge clk);
         if (!cmd_ready) any_low = 1'b1;
      end
      checkOutput("frozen_no_scan", 80'(any_low), 80'd0);
      checkOutput("frozen_width", 80'(width_us), packed_exp());
      en = 1'b1;
      wait_scan();
      for (int i = 0; i < N_CH; i++) exp_w[i] = 16'd1760;
      checkOutput("resume_step", 80'(width_us), packed_exp());

      // reset asserted in the middle of a scan
      wait_ready_low();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      for (int i = 0; i < N_CH; i++) exp_w[i] = 16'd1500;
      checkOutput("rst_mid_width", 80'(width_us), packed_exp());
      checkOutput("rst_mid_ready", 80'(cmd_ready), 80'd0);
      checkOutput("rst_mid_at_target", 80'(at_target), 80'b11111);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_release_ready", 80'(cmd_ready), 80'd1);
      wait_scan();
      checkOutput("post_rst_width", 80'(width_us), packed_exp());
      checkOutput("post_rst_done", 80'(all_done), 80'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
